dma_priority_arbiter_n: RTL and testbench
=========================================

// Module: dma_priority_arbiter_n
// PURPOSE
//  Parametrised N-channel DREQ/DACK priority and handshake engine for the DMA controller.
//  Successor to the fixed 4-channel priority logic: adds configurable channel count,
//  rotating priority with wrap for any NUM_CH, programmable DREQ/DACK polarity,
//  per-channel masking and HLDA-loss abort.
//  Sits between the request pins and timing-and-control: raises HRQ, waits for HLDA,
//  grants one channel, and holds the grant until transferDone.
// PARAMETERS
//  NUM_CH    4   number of DMA channels, >=2, need not be a power of 2
//  CH_W      $clog2(NUM_CH)   localparam, width of channel index/pointer
// PORTS
//  CLK           in   1        clock, all state updates on posedge
//  RESET         in   1        asynchronous, active-high reset
//  DREQ          in   NUM_CH   channel requests, polarity per dreqSense
//  maskReg       in   NUM_CH   1 = channel masked, its request ignored
//  priorityType  in   1        0 = fixed (ch0 highest), 1 = rotating
//  dreqSense     in   1        0 = DREQ active-high, 1 = active-low
//  dackSense     in   1        0 = DACK active-high, 1 = active-low
//  HLDA          in   1        hold acknowledge from bus master
//  transferDone  in   1        1-cycle pulse from timing-and-control: service ended
//  HRQ           out  1        hold request
//  DACK          out  NUM_CH   one-hot (in active sense) channel acknowledge
//  grantValid    out  1        1 while a channel is granted
//  grantChannel  out  CH_W     index of granted channel, valid when grantValid
//  priorityPtr   out  CH_W     current highest-priority channel
// BEHAVIOUR
//  - req = (DREQ ^ {NUM_CH{dreqSense}}) & ~maskReg, combinational.
//  - Reset (async, immediate, no clock edge needed): state=IDLE, HRQ=0, grantValid=0,
//    grantChannel=0, priorityPtr=0, DACK = all inactive ({NUM_CH{dackSense}}).
//  - All outputs registered. DACK = grant one-hot XOR {NUM_CH{dackSense}}.
//  - FSM states IDLE, REQ, GRANT (one-hot encoding):
//    IDLE : |req -> REQ, HRQ=1 (HRQ rises 1 cycle after req seen).
//    REQ  : HLDA=1 && |req -> arbitrate, latch winner, GRANT, DACK/grantValid set next edge.
//           HLDA=0 && req==0 -> IDLE, HRQ=0. Otherwise stay.
//    GRANT: HLDA=0 -> abort: IDLE, HRQ=0, DACK inactive, grantValid=0, no rotation.
//           transferDone=1 -> IDLE, HRQ=0, DACK inactive. If priorityType=1,
//           priorityPtr <= (winner+1==NUM_CH) ? 0 : winner+1.
//           HLDA loss takes precedence over transferDone in the same cycle.
//  - Arbitration: scan from priorityPtr upward modulo NUM_CH; first set req bit wins.
//    Fixed mode always uses pointer 0.
//  - Latency: with HLDA already high, DREQ seen at edge t -> HRQ after t, DACK after t+1.
//  - Minimum 1 IDLE cycle between grants: HRQ drops for >=1 cycle after each transfer.
//  - Changes during GRANT to DREQ, maskReg or priorityType do not alter the current grant.
//    transferDone outside GRANT is ignored.
//  - priorityType 1->0: priorityPtr <= 0 on next edge, in any state.
//  - dreqSense/dackSense are static config; changes are only legal in IDLE.
//  - Invariants: DACK has at most one active bit; active DACK implies HRQ && grantValid.
// TESTING
//  1 NUM_CH=4 fixed, HLDA=1, DREQ=4'b0110 -> HRQ=1 after 1 clk, DACK=4'b0010 after 2,
//    grantChannel=1; transferDone -> DACK=4'b0000, HRQ=0 next clk.
//  2 NUM_CH=4 rotating, DREQ=4'b1111 held, 5 transfers -> DACK order 0001,0010,0100,1000,0001;
//    priorityPtr 1,2,3,0,1.
//  3 DREQ=4'b0001, HLDA=0, DREQ removed while in REQ -> HRQ=0 next clk, DACK never active.
//  4 HLDA dropped in GRANT on ch2, rotating -> DACK inactive and HRQ=0 next clk,
//    priorityPtr unchanged.
//  5 dackSense=1: reset -> DACK=4'b1111; RESET pulsed mid-GRANT between edges ->
//    DACK=4'b1111, HRQ=0 immediately.
//  6 NUM_CH=5 rotating, grant ch4 -> priorityPtr wraps to 0;
//    maskReg=5'b00001 with DREQ=5'b00001 -> HRQ stays 0.

Source files
------------

// File: rtl/dma_priority_arbiter_n.sv
// N-channel DREQ/DACK priority and handshake engine: raises HRQ, waits for HLDA,
// grants one channel (fixed or rotating priority) and holds it until transferDone.
module dma_priority_arbiter_n #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              priorityType,
  input  logic              dreqSense,
  input  logic              dackSense,
  input  logic              HLDA,
  input  logic              transferDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [CH_W-1:0]   grantChannel,
  output logic [CH_W-1:0]   priorityPtr
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    REQ   = 3'b010,
    GRANT = 3'b100
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant_oh_q, grant_oh_d;
  logic              hrq_d, grant_valid_d;
  logic [CH_W-1:0]   grant_ch_d, ptr_d;
  logic [CH_W-1:0]   base, winner, hi_ch, lo_ch;
  logic              hi_found;

  assign req = (DREQ ^ {NUM_CH{dreqSense}}) & ~maskReg;

  // dackSense is static config, so polarity is applied after the grant register;
  // this also makes reset drive DACK inactive for either polarity.
  assign DACK = grant_oh_q ^ {NUM_CH{dackSense}};

  // Rotating scan: lowest requester at or above the pointer, else lowest overall (wrap).
  always_comb begin
    base     = priorityType ? priorityPtr : '0;
    hi_ch    = '0;
    lo_ch    = '0;
    hi_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_ch = CH_W'(i);
        if (CH_W'(i) >= base) begin
          hi_ch    = CH_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi_ch : lo_ch;
  end

  // NOTE: state and outputs use non-blocking assignments so every register samples
  // pre-edge values; the comb blocks below use blocking assignments.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      HRQ          <= 1'b0;
      grantValid   <= 1'b0;
      grantChannel <= '0;
      priorityPtr  <= '0;
      grant_oh_q   <= '0;
    end else begin
      state_q      <= state_d;
      HRQ          <= hrq_d;
      grantValid   <= grant_valid_d;
      grantChannel <= grant_ch_d;
      priorityPtr  <= ptr_d;
      grant_oh_q   <= grant_oh_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = REQ;
      REQ: begin
        if (HLDA && |req)        state_d = GRANT;
        else if (!HLDA && !(|req)) state_d = IDLE;
      end
      GRANT:   if (!HLDA || transferDone) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hrq_d         = (state_d != IDLE);
    grant_valid_d = (state_d == GRANT);
    grant_ch_d    = grantChannel;
    grant_oh_d    = (state_d == GRANT) ? grant_oh_q : '0;
    ptr_d         = priorityType ? priorityPtr : '0;
    if (state_q == REQ && state_d == GRANT) begin
      grant_ch_d         = winner;
      grant_oh_d         = '0;
      grant_oh_d[winner] = 1'b1;
    end
    // HLDA loss aborts without rotating; only a completed transfer advances the pointer.
    if (state_q == GRANT && HLDA && transferDone && priorityType)
      ptr_d = (grantChannel == CH_W'(NUM_CH - 1)) ? '0 : grantChannel + 1'b1;
  end

endmodule

// File: tb/tb_dma_priority_arbiter_n.sv
// Bench for dma_priority_arbiter_n: 4- and 5-channel instances driven from a vector
// table through an expected-result queue, plus a hand-written async-reset sequence.
module tb_dma_priority_arbiter_n;

  typedef struct {
    bit         use5;
    logic [4:0] dreq, mask;
    logic       ptype, dsense, hlda, done;
    logic       e_hrq;
    logic [4:0] e_dack;
    logic       e_gv;
    logic [2:0] e_gch, e_ptr;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] dreq4, mask4;
  logic [4:0] dreq5, mask5;
  logic       hlda4, hlda5, ptype, dreq_sense, dack_sense, done;
  logic       hrq4, gv4, hrq5, gv5;
  logic [3:0] dack4;
  logic [4:0] dack5;
  logic [1:0] gch4, ptr4;
  logic [2:0] gch5, ptr5;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  vec_t sb_q[$];
  vec_t e;

  always #5 CLK = ~CLK;

  dma_priority_arbiter_n #(.NUM_CH(4)) u_dut4 (
    .CLK(CLK), .RESET(RESET), .DREQ(dreq4), .maskReg(mask4), .priorityType(ptype),
    .dreqSense(dreq_sense), .dackSense(dack_sense), .HLDA(hlda4), .transferDone(done),
    .HRQ(hrq4), .DACK(dack4), .grantValid(gv4), .grantChannel(gch4), .priorityPtr(ptr4)
  );

  dma_priority_arbiter_n #(.NUM_CH(5)) u_dut5 (
    .CLK(CLK), .RESET(RESET), .DREQ(dreq5), .maskReg(mask5), .priorityType(ptype),
    .dreqSense(dreq_sense), .dackSense(dack_sense), .HLDA(hlda5), .transferDone(done),
    .HRQ(hrq5), .DACK(dack5), .grantValid(gv5), .grantChannel(gch5), .priorityPtr(ptr5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(int u, int dreq, int mask, int pt, int ds, int hl, int dn,
                              int hrq, int dack, int gv, int gch, int ptr);
    vec_t v;
    v.use5 = (u != 0);     v.dreq = 5'(dreq); v.mask = 5'(mask);
    v.ptype = 1'(pt);      v.dsense = 1'(ds); v.hlda = 1'(hl);  v.done = 1'(dn);
    v.e_hrq = 1'(hrq);     v.e_dack = 5'(dack); v.e_gv = 1'(gv);
    v.e_gch = 3'(gch);     v.e_ptr = 3'(ptr);
    vecs.push_back(v);
  endfunction

  // The unselected instance is fully masked with HLDA low so it idles.
  task automatic apply(input vec_t v);
    ptype = v.ptype; dreq_sense = v.dsense; done = v.done;
    if (v.use5) begin
      dreq5 = v.dreq; mask5 = v.mask; hlda5 = v.hlda;
      dreq4 = '0;     mask4 = '1;     hlda4 = 1'b0;
    end else begin
      dreq4 = v.dreq[3:0]; mask4 = v.mask[3:0]; hlda4 = v.hlda;
      dreq5 = '0;          mask5 = '1;          hlda5 = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Fixed priority, HLDA high, DREQ=0110: HRQ after 1 clk, DACK=0010 after 2.
    //  u  dreq  mask pt ds hl dn  hrq dack gv gch ptr
    add(0, 'h6, 0, 0, 0, 1, 0,  1, 'h0, 0, 0, 0);
    add(0, 'h6, 0, 0, 0, 1, 0,  1, 'h2, 1, 1, 0);
    add(0, 'h6, 0, 0, 0, 1, 0,  1, 'h2, 1, 1, 0);
    add(0, 'h6, 0, 0, 0, 1, 1,  0, 'h0, 0, 1, 0);
    add(0, 'h0, 0, 0, 0, 1, 0,  0, 'h0, 0, 1, 0);
    // Rotating, all requesting: grants 0,1,2,3,0 and pointer 1,2,3,0,1.
    for (int k = 0; k < 5; k++) begin
      add(0, 'hf, 0, 1, 0, 1, 0,  1, 'h0, 0, (k == 0) ? 1 : (k - 1) % 4, k % 4);
      add(0, 'hf, 0, 1, 0, 1, 0,  1, 1 << (k % 4), 1, k % 4, k % 4);
      add(0, 'hf, 0, 1, 0, 1, 1,  0, 'h0, 0, k % 4, (k + 1) % 4);
    end
    // HLDA lost in GRANT on ch2 together with transferDone: abort wins, no rotation.
    add(0, 'h4, 0, 1, 0, 1, 0,  1, 'h0, 0, 0, 1);
    add(0, 'h4, 0, 1, 0, 1, 0,  1, 'h4, 1, 2, 1);
    add(0, 'h4, 0, 1, 0, 0, 1,  0, 'h0, 0, 2, 1);
    // Request withdrawn while waiting for HLDA.
    add(0, 'h1, 0, 1, 0, 0, 0,  1, 'h0, 0, 2, 1);
    add(0, 'h1, 0, 1, 0, 0, 0,  1, 'h0, 0, 2, 1);
    add(0, 'h0, 0, 1, 0, 0, 0,  0, 'h0, 0, 2, 1);
    // Rotating -> fixed clears the pointer; masked requests never raise HRQ.
    add(0, 'h0, 0, 0, 0, 0, 0,  0, 'h0, 0, 2, 0);
    add(0, 'h2, 2, 0, 0, 1, 0,  0, 'h0, 0, 2, 0);
    add(0, 'h2, 2, 0, 0, 1, 0,  0, 'h0, 0, 2, 0);
    // Mask/DREQ/priorityType changes during GRANT leave the grant alone.
    add(0, 'h3, 0, 0, 0, 1, 0,  1, 'h0, 0, 2, 0);
    add(0, 'h3, 0, 0, 0, 1, 0,  1, 'h1, 1, 0, 0);
    add(0, 'h2, 1, 1, 0, 1, 0,  1, 'h1, 1, 0, 0);
    add(0, 'h2, 1, 1, 0, 1, 1,  0, 'h0, 0, 0, 1);
    add(0, 'h0, 0, 0, 0, 1, 0,  0, 'h0, 0, 0, 0);
    // transferDone outside GRANT is ignored.
    add(0, 'h0, 0, 0, 0, 1, 1,  0, 'h0, 0, 0, 0);
    add(0, 'h1, 0, 0, 0, 0, 1,  1, 'h0, 0, 0, 0);
    add(0, 'h1, 0, 0, 0, 1, 1,  1, 'h1, 1, 0, 0);
    add(0, 'h0, 0, 0, 0, 1, 1,  0, 'h0, 0, 0, 0);
    // Active-low DREQ: 1111 is idle, 1011 requests ch2.
    add(0, 'hf, 0, 0, 1, 1, 0,  0, 'h0, 0, 0, 0);
    add(0, 'hb, 0, 0, 1, 1, 0,  1, 'h0, 0, 0, 0);
    add(0, 'hb, 0, 0, 1, 1, 0,  1, 'h4, 1, 2, 0);
    add(0, 'hb, 0, 0, 1, 1, 1,  0, 'h0, 0, 2, 0);
    add(0, 'h0, 0, 0, 0, 0, 0,  0, 'h0, 0, 2, 0);
    // Five channels, rotating: grant ch3 then ch4, pointer 4 then wraps to 0.
    add(1, 'h08, 0, 1, 0, 1, 0,  1, 'h00, 0, 0, 0);
    add(1, 'h08, 0, 1, 0, 1, 0,  1, 'h08, 1, 3, 0);
    add(1, 'h08, 0, 1, 0, 1, 1,  0, 'h00, 0, 3, 4);
    add(1, 'h10, 0, 1, 0, 1, 0,  1, 'h00, 0, 3, 4);
    add(1, 'h10, 0, 1, 0, 1, 0,  1, 'h10, 1, 4, 4);
    add(1, 'h10, 0, 1, 0, 1, 1,  0, 'h00, 0, 4, 0);
    add(1, 'h01, 1, 1, 0, 1, 0,  0, 'h00, 0, 4, 0);
    add(1, 'h01, 1, 1, 0, 1, 0,  0, 'h00, 0, 4, 0);

    dreq4 = '0; mask4 = '0; dreq5 = '0; mask5 = '0; hlda4 = 1'b0; hlda5 = 1'b0;
    ptype = 1'b0; dreq_sense = 1'b0; dack_sense = 1'b0; done = 1'b0;

    #1 RESET = 1'b1;
    #1;
    check("rst.hrq4",  32'(hrq4),  32'd0);
    check("rst.dack4", 32'(dack4), 32'd0);
    check("rst.gv4",   32'(gv4),   32'd0);
    check("rst.gch4",  32'(gch4),  32'd0);
    check("rst.ptr4",  32'(ptr4),  32'd0);
    check("rst.dack5", 32'(dack5), 32'd0);
    @(negedge CLK) RESET = 1'b0;

    foreach (vecs[i]) begin
      @(negedge CLK);
      apply(vecs[i]);
      sb_q.push_back(vecs[i]);
      @(posedge CLK);
      #1;
      e = sb_q.pop_front();
      if (e.use5) begin
        check($sformatf("v%0d.hrq", i),  32'(hrq5),  32'(e.e_hrq));
        check($sformatf("v%0d.dack", i), 32'(dack5), 32'(e.e_dack));
        check($sformatf("v%0d.gv", i),   32'(gv5),   32'(e.e_gv));
        check($sformatf("v%0d.gch", i),  32'(gch5),  32'(e.e_gch));
        check($sformatf("v%0d.ptr", i),  32'(ptr5),  32'(e.e_ptr));
      end else begin
        check($sformatf("v%0d.hrq", i),  32'(hrq4),  32'(e.e_hrq));
        check($sformatf("v%0d.dack", i), 32'(dack4), 32'(e.e_dack[3:0]));
        check($sformatf("v%0d.gv", i),   32'(gv4),   32'(e.e_gv));
        check($sformatf("v%0d.gch", i),  32'(gch4),  32'(e.e_gch[1:0]));
        check($sformatf("v%0d.ptr", i),  32'(ptr4),  32'(e.e_ptr[1:0]));
      end
    end

    // Active-low DACK: reset gives all-ones, and a reset pulse between edges
    // mid-GRANT releases DACK and HRQ without waiting for a clock.
    @(negedge CLK);
    dack_sense = 1'b1;
    RESET = 1'b1;
    #1;
    check("lowdack.rst.dack", 32'(dack4), 32'hf);
    check("lowdack.rst.hrq",  32'(hrq4),  32'd0);
    @(negedge CLK);
    RESET = 1'b0; dreq4 = 4'b0001; mask4 = '0; hlda4 = 1'b1; ptype = 1'b0; dreq_sense = 1'b0;
    @(posedge CLK);
    #1;
    check("lowdack.req.hrq",  32'(hrq4),  32'd1);
    check("lowdack.req.dack", 32'(dack4), 32'hf);
    @(posedge CLK);
    #1;
    check("lowdack.grant.dack", 32'(dack4), 32'he);
    check("lowdack.grant.gv",   32'(gv4),   32'd1);
    #2 RESET = 1'b1;
    #1;
    check("lowdack.async.dack", 32'(dack4), 32'hf);
    check("lowdack.async.hrq",  32'(hrq4),  32'd0);
    check("lowdack.async.gv",   32'(gv4),   32'd0);
    @(negedge CLK);
    RESET = 1'b0; dreq4 = '0; hlda4 = 1'b0; dack_sense = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
